irq_ctrl18: RTL and testbench
=============================

Name: irq_ctrl18

Overview:
- Interrupt controller that drives the Core18 VECTOR input.
- Collects 15 external request lines, synchronises them, and latches edge or level events.
- Applies a mask and global enable, then presents the highest-priority pending source as a 4-bit vector. 0 means no request.
- Software reads and controls it through the Core18 port bus (PORT_RD/PORT_WR, ADRS, DATAOUT/DATAIN). The ISR clears the pending bit before RTI.

Parameters:
- PORT_BASE, 18'o000040: port address of register 0. Registers occupy PORT_BASE..PORT_BASE+3.
- SYNC_STAGES, 2: synchroniser depth on IRQ inputs. Legal values 2..3.
- RESET_MASK, 15'h0000: enable-mask value after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IRQ  in  15  async request lines. IRQ[i-1] maps to vector i.
- ADRS  in  18  core port address.
- DATAOUT  in  18  core write data.
- PORT_WR  in  1  core port write strobe, one cycle.
- PORT_RD  in  1  core port read strobe.
- DATAIN  out  18  read data to core. Combinational from ADRS when a read hits; otherwise 0.
- VECTOR  out  4  registered interrupt vector to Core18. 0 = none.

Behaviour:
- Register map (offset from PORT_BASE):
  - 0 MASK: R/W. Bits 14:0 enable sources 1..15. Bit 17 is the global enable (GIE). Bits 16:15 read 0.
  - 1 PEND: R. Bits 14:0 are pending flags. Write-1-to-clear, applies to edge sources only.
  - 2 MODE: R/W. Bits 14:0: 1 = rising-edge source, 0 = level source.
  - 3 CUR: R. Bits 3:0 = current VECTOR value.
- Address decode: an access hits when ADRS[17:2] == PORT_BASE[17:2]. Writes take effect on the CLK edge where PORT_WR=1.
- Reset (async, RESET_N=0):
  - VECTOR=0, PEND=0, MODE=0 (all level), MASK[14:0]=RESET_MASK, GIE=0.
  - All sync and edge-history flops are cleared.
  - DATAIN is combinational and therefore reads 0 with no strobe.
- Synchroniser: SYNC_STAGES flops per line, followed by one history flop for edge detect.
- Edge source: PEND[i] is set on a synced 0->1 transition and held until cleared by W1C or by a MODE change to level.
- Level source: PEND[i] equals the synced level each cycle. W1C to that bit is ignored.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, so no event is lost.
- Vector select: eligible[i] = PEND[i] & MASK[i] & GIE. The next VECTOR is the lowest eligible index+1 (vector 1 = highest priority), else 0. VECTOR is registered and updates every cycle.
- Latency from IRQ pin rising (setup met) to VECTOR valid = SYNC_STAGES+2 cycles (4 at default).
- VECTOR drops to 0 (or the next eligible vector) one cycle after the W1C edge clears the last eligible bit.
- A mask or GIE write takes effect on VECTOR one cycle after the write edge.
- A higher-priority source becoming eligible replaces a lower VECTOR on the next cycle. The core handles nesting via its LEVEL.
- Level source deasserted at the pin: VECTOR drops SYNC_STAGES+1 cycles later.
- MODE write edge->level: PEND for that bit takes the synced level from the next cycle.
- MODE write level->edge: PEND clears, and the edge history is reloaded so no false edge fires.
- PORT_RD and PORT_WR both high: the write occurs; DATAIN shows the pre-write value.
- Reset asserted mid-request: VECTOR=0 immediately (async). Pending events are discarded.

Decomposition:
- Shared package irq18_pkg:
  - register offsets (OFS_MASK=0, OFS_PEND=1, OFS_MODE=2, OFS_CUR=3)
  - GIE_BIT=17, NUM_SRC=15, VEC_NONE=4'd0
- Sub-module irq18_sync_edge, instantiated once per source (generate). Contains the synchroniser, edge detect and pending flop, with inputs mode, clr and synced level. The top holds the register file, decode, priority encoder and VECTOR register.

Test Plan:
- Reset: RESET_N low with IRQ=15'h7FFF. Expect VECTOR=0, all reads 0. Release, no writes: VECTOR stays 0 (GIE=0).
- Edge latch and priority:
  - Write MASK=18'o400024 (GIE + bits 2,4 = vectors 3,5), MODE=15'h7FFF.
  - Pulse IRQ[4] for 1 cycle: VECTOR=5 exactly 4 cycles after the pulse and held after IRQ drops.
  - Pulse IRQ[2]: VECTOR=3 the cycle after its PEND sets.
- W1C: with vectors 3 and 5 pending, write PEND=4. Next cycle VECTOR=5. Write PEND=16: VECTOR=0. Reading PEND returns 0.
- Set/clear collision: pulse IRQ[4] timed so the edge lands in the same cycle as a W1C of bit 4. PEND[4] stays 1 and VECTOR=5.
- Level source: MODE=0, MASK enables bit 0, hold IRQ[0]=1. VECTOR=1, and W1C has no effect. Drop IRQ[0]: VECTOR=0 3 cycles later.
- Masking and async reset: pending vector 5, write MASK GIE=0, then VECTOR=0 next cycle. Re-enable: VECTOR=5. Assert RESET_N mid-hold: VECTOR=0 immediately, PEND=0 after release.

Source files
------------

// File: rtl/irq18_pkg.sv
// Shared constants for the Core18 interrupt controller: register offsets,
// source count, global-enable bit position and the "no request" vector.
// Latency: n/a (constants only). Backpressure: n/a.
package irq18_pkg;

  localparam int unsigned NUM_SRC  = 15;
  localparam int unsigned GIE_BIT  = 17;

  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_MODE = 2'd2;
  localparam logic [1:0] OFS_CUR  = 2'd3;

  localparam logic [3:0] VEC_NONE = 4'd0;

endpackage

// File: rtl/irq18_sync_edge.sv
// One interrupt source: synchroniser, edge history and pending flag.
// Latency: pin to pend_o is SYNC_STAGES+1 edges (edge mode), SYNC_STAGES (level mode).
// Backpressure: none; clr_i is a single-cycle W1C pulse, a same-cycle edge wins.
// Ports: clk_i/rst_ni clock and async reset, irq_i raw pin, mode_i 1=edge 0=level,
//        clr_i write-1-to-clear strobe, pend_o pending flag seen by software.
module irq18_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic mode_i,
  input  logic clr_i,
  output logic pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pend_q;
  logic                   pend_d;
  logic                   lvl;
  logic                   rise;

  assign lvl  = sync_q[SYNC_STAGES-1];
  // History always tracks the synced level, so switching a source to edge
  // mode never sees a stale 0 and fires a false edge.
  assign rise = lvl & ~hist_q;

  // The latch is held clear while in level mode; this also makes the
  // level->edge switch start from an empty pending flag.
  always_comb begin
    pend_d = 1'b0;
    if (mode_i) begin
      pend_d = rise | (pend_q & ~clr_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      hist_q <= lvl;
      pend_q <= pend_d;
    end
  end

  // Level sources report the synced pin directly, so deassertion is seen
  // one cycle earlier than an edge source would latch.
  assign pend_o = mode_i ? pend_q : lvl;

endmodule

// File: rtl/irq_ctrl18.sv
// Core18 interrupt controller: 15 sources, mask/GIE, fixed priority, registered VECTOR.
// Latency: edge pin rise to VECTOR = SYNC_STAGES+2 cycles; register writes reach VECTOR one cycle after the write edge.
// Backpressure: none; port accesses complete in a single cycle, DATAIN is combinational.
// Ports: CLK/RESET_N clock and async reset, IRQ[14:0] raw requests (IRQ[i-1] -> vector i),
//        ADRS/DATAOUT/PORT_WR/PORT_RD core port bus in, DATAIN read data out, VECTOR to core.
module irq_ctrl18
  import irq18_pkg::*;
#(
  parameter logic [17:0] PORT_BASE   = 18'o000040,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [14:0] RESET_MASK  = 15'h0000
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [14:0]  IRQ,
  input  logic [17:0]  ADRS,
  input  logic [17:0]  DATAOUT,
  input  logic         PORT_WR,
  input  logic         PORT_RD,
  output logic [17:0]  DATAIN,
  output logic [3:0]   VECTOR
);

  logic               hit;
  logic [1:0]         ofs;
  logic               wr_en;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic               gie_q, gie_d;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] elig;
  logic [3:0]         vec_q, vec_d;
  logic               unused_dat;

  assign hit   = (ADRS[17:2] == PORT_BASE[17:2]);
  assign ofs   = ADRS[1:0];
  assign wr_en = PORT_WR & hit;
  assign clr   = (wr_en && ofs == OFS_PEND) ? DATAOUT[NUM_SRC-1:0] : '0;

  // DATAOUT[16:15] have no backing storage; MASK reads them as 0.
  assign unused_dat = ^DATAOUT[16:15];

  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    mode_d = mode_q;
    if (wr_en && ofs == OFS_MASK) begin
      mask_d = DATAOUT[NUM_SRC-1:0];
      gie_d  = DATAOUT[GIE_BIT];
    end
    if (wr_en && ofs == OFS_MODE) begin
      mode_d = DATAOUT[NUM_SRC-1:0];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq18_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk_i  (CLK),
      .rst_ni (RESET_N),
      .irq_i  (IRQ[g]),
      .mode_i (mode_q[g]),
      .clr_i  (clr[g]),
      .pend_o (pend[g])
    );
  end

  assign elig = pend & mask_q & {NUM_SRC{gie_q}};

  // Scan from the top so the lowest eligible index is the last to assign.
  always_comb begin
    vec_d = VEC_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        vec_d = 4'(i + 1);
      end
    end
  end

  // Reads show pre-write state even when a write is on the same cycle.
  always_comb begin
    DATAIN = '0;
    if (PORT_RD && hit) begin
      case (ofs)
        OFS_MASK: DATAIN = {gie_q, 2'b00, mask_q};
        OFS_PEND: DATAIN = {3'b000, pend};
        OFS_MODE: DATAIN = {3'b000, mode_q};
        default:  DATAIN = {14'd0, vec_q};
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_q <= RESET_MASK;
      gie_q  <= 1'b0;
      mode_q <= '0;
      vec_q  <= VEC_NONE;
    end else begin
      mask_q <= mask_d;
      gie_q  <= gie_d;
      mode_q <= mode_d;
      vec_q  <= vec_d;
    end
  end

  assign VECTOR = vec_q;

endmodule

// File: tb/tb_irq_ctrl18.sv
// Bench for irq_ctrl18: reference model plus per-cycle compare and directed literal checks.
// Latency: n/a. Backpressure: n/a.
module tb_irq_ctrl18;

  localparam int          SYNC = 2;
  localparam logic [17:0] BASE = 18'o000040;

  logic        CLK;
  logic        RESET_N;
  logic [14:0] IRQ;
  logic [17:0] ADRS;
  logic [17:0] DATAOUT;
  logic        PORT_WR;
  logic        PORT_RD;
  logic [17:0] DATAIN;
  logic [3:0]  VECTOR;

  int n_cmp = 0;
  int n_err = 0;

  irq_ctrl18 #(
    .PORT_BASE   (BASE),
    .SYNC_STAGES (SYNC),
    .RESET_MASK  (15'h0000)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .IRQ     (IRQ),
    .ADRS    (ADRS),
    .DATAOUT (DATAOUT),
    .PORT_WR (PORT_WR),
    .PORT_RD (PORT_RD),
    .DATAIN  (DATAIN),
    .VECTOR  (VECTOR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // pin_at[k] = IRQ as sampled k+1 clock edges ago.
  logic [14:0] pin_at [SYNC+1];
  logic [14:0] m_mask, m_mode, m_latch;
  logic        m_gie;
  logic [3:0]  m_vec;
  logic [14:0] m_seen, m_rise, m_clr, m_want;
  logic [3:0]  m_next;
  logic        m_hit;
  logic [17:0] m_rd;

  always_comb begin
    m_hit  = ((ADRS >> 2) == (BASE >> 2));
    // a pin change is visible after SYNC edges; edge = newly-high this cycle
    m_seen = (m_latch & m_mode) | (pin_at[SYNC-1] & ~m_mode);
    m_rise = pin_at[SYNC-1] & ~pin_at[SYNC];
    m_clr  = (PORT_WR && m_hit && ADRS[1:0] == 2'd1) ? DATAOUT[14:0] : 15'd0;
    m_want = m_gie ? (m_seen & m_mask) : 15'd0;
    m_next = 4'd0;
    for (int i = 1; i <= 15; i++) begin
      if (m_next == 4'd0 && m_want[i-1]) m_next = 4'(i);
    end
    m_rd = 18'd0;
    if (PORT_RD && m_hit) begin
      case (ADRS[1:0])
        2'd0:    m_rd = {m_gie, 2'b00, m_mask};
        2'd1:    m_rd = {3'b000, m_seen};
        2'd2:    m_rd = {3'b000, m_mode};
        default: m_rd = {14'd0, m_vec};
      endcase
    end
  end

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k <= SYNC; k++) pin_at[k] <= 15'd0;
      m_mask  <= 15'd0;
      m_mode  <= 15'd0;
      m_latch <= 15'd0;
      m_gie   <= 1'b0;
      m_vec   <= 4'd0;
    end else begin
      m_vec   <= m_next;
      m_latch <= m_mode & (m_rise | (m_latch & ~m_clr));
      if (PORT_WR && m_hit && ADRS[1:0] == 2'd0) begin
        m_mask <= DATAOUT[14:0];
        m_gie  <= DATAOUT[17];
      end
      if (PORT_WR && m_hit && ADRS[1:0] == 2'd2) m_mode <= DATAOUT[14:0];
      pin_at[0] <= IRQ;
      for (int k = 1; k <= SYNC; k++) pin_at[k] <= pin_at[k-1];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      #2;
      chk("model_vector", {14'd0, VECTOR}, {14'd0, m_vec});
      chk("model_datain", DATAIN, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic vec_at(input string nm, input logic [3:0] exp);
    #1 chk(nm, {14'd0, VECTOR}, {14'd0, exp});
  endtask

  task automatic wr(input logic [1:0] o, input logic [17:0] d);
    @(negedge CLK);
    ADRS = BASE + 18'(o); DATAOUT = d; PORT_WR = 1'b1;
    @(negedge CLK);
    PORT_WR = 1'b0; DATAOUT = 18'd0;
  endtask

  task automatic rd(input string nm, input logic [17:0] adr, input logic [17:0] exp);
    @(negedge CLK);
    ADRS = adr; PORT_RD = 1'b1;
    #1 chk(nm, DATAIN, exp);
    @(negedge CLK);
    PORT_RD = 1'b0;
  endtask

  task automatic pulse(input logic [14:0] p);
    @(negedge CLK); IRQ = p;
    @(negedge CLK); IRQ = 15'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RESET_N = 1'b1; IRQ = 15'h7FFF; ADRS = BASE; DATAOUT = 18'd0;
    PORT_WR = 1'b0; PORT_RD = 1'b0;
    #1 RESET_N = 1'b0;

    // reset with all requests high
    step(3);
    vec_at("rst_vec", 4'd0);
    rd("rst_mask", BASE + 18'd0, 18'd0);
    rd("rst_pend", BASE + 18'd1, 18'd0);
    rd("rst_mode", BASE + 18'd2, 18'd0);
    rd("rst_cur",  BASE + 18'd3, 18'd0);
    @(negedge CLK) RESET_N = 1'b1;
    step(8);
    vec_at("nogie_vec", 4'd0);
    rd("lvl_pend_all", BASE + 18'd1, 18'h07FFF);
    rd("miss_read", BASE + 18'd5, 18'd0);
    @(negedge CLK) IRQ = 15'd0;
    step(4);

    // edge latch, exact latency and priority
    wr(2'd2, 18'h07FFF);
    wr(2'd0, 18'o400024);
    step(2);
    pulse(15'h0010);
    @(negedge CLK) vec_at("e5_n2", 4'd0);
    @(negedge CLK) vec_at("e5_n3", 4'd0);
    @(negedge CLK) vec_at("e5_n4", 4'd5);
    step(3);
    vec_at("e5_hold", 4'd5);
    pulse(15'h0004);
    @(negedge CLK) vec_at("e3_n2", 4'd5);
    @(negedge CLK) vec_at("e3_n3", 4'd5);
    @(negedge CLK) vec_at("e3_n4", 4'd3);
    rd("pend_3_5", BASE + 18'd1, 18'h00014);

    // write-1-to-clear
    wr(2'd1, 18'd4);
    vec_at("w1c_same", 4'd3);
    step(1);
    vec_at("w1c_to5", 4'd5);
    wr(2'd1, 18'd16);
    step(1);
    vec_at("w1c_to0", 4'd0);
    rd("w1c_pend", BASE + 18'd1, 18'd0);

    // edge arrives on the same edge as a W1C of that bit
    @(negedge CLK) IRQ = 15'h0010;
    @(negedge CLK) IRQ = 15'd0;
    @(negedge CLK) begin ADRS = BASE + 18'd1; DATAOUT = 18'd16; PORT_WR = 1'b1; end
    @(negedge CLK) begin PORT_WR = 1'b0; DATAOUT = 18'd0; end
    @(negedge CLK) vec_at("coll_vec", 4'd5);
    rd("coll_pend", BASE + 18'd1, 18'h00010);
    wr(2'd1, 18'd16);
    step(2);
    vec_at("coll_cleared", 4'd0);

    // level source
    wr(2'd2, 18'd0);
    wr(2'd0, 18'o400001);
    @(negedge CLK) IRQ = 15'h0001;
    @(negedge CLK);
    @(negedge CLK) vec_at("lvl_n2", 4'd0);
    @(negedge CLK) vec_at("lvl_n3", 4'd1);
    wr(2'd1, 18'd1);
    step(2);
    vec_at("lvl_w1c_ignored", 4'd1);
    rd("lvl_pend", BASE + 18'd1, 18'd1);
    @(negedge CLK) IRQ = 15'd0;
    @(negedge CLK);
    @(negedge CLK) vec_at("lvl_drop_n2", 4'd1);
    @(negedge CLK) vec_at("lvl_drop_n3", 4'd0);

    // masking, read/write collision and async reset
    wr(2'd2, 18'h07FFF);
    wr(2'd0, 18'o400024);
    pulse(15'h0010);
    step(4);
    vec_at("mask_pend5", 4'd5);
    wr(2'd0, 18'o000024);
    vec_at("gie_off_same", 4'd5);
    step(1);
    vec_at("gie_off", 4'd0);
    wr(2'd0, 18'o400024);
    step(1);
    vec_at("gie_on", 4'd5);
    @(negedge CLK) begin ADRS = BASE; DATAOUT = 18'o400001; PORT_WR = 1'b1; PORT_RD = 1'b1; end
    #1 chk("rdwr_prewrite", DATAIN, 18'o400024);
    @(negedge CLK) begin PORT_WR = 1'b0; PORT_RD = 1'b0; DATAOUT = 18'd0; end
    rd("rdwr_after", BASE + 18'd0, 18'o400001);
    vec_at("mask_bit0_only", 4'd0);
    wr(2'd0, 18'o400024);
    step(1);
    vec_at("reenable", 4'd5);
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    vec_at("async_rst_vec", 4'd0);
    step(2);
    @(negedge CLK) RESET_N = 1'b1;
    step(4);
    rd("post_rst_pend", BASE + 18'd1, 18'd0);
    rd("post_rst_mask", BASE + 18'd0, 18'd0);
    vec_at("post_rst_vec", 4'd0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
